// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: instruction field layout, NOP encoding and default width.
package mips_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int INSTR_W        = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int REG_W  = RS_MSB - RS_LSB + 1;

    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = SHAMT_MSB - SHAMT_LSB + 1;

    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W   = FUNCT_MSB - FUNCT_LSB + 1;

    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int IMM16_W   = IMM16_MSB - IMM16_LSB + 1;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_field_split.sv
// Splits a MIPS instruction word into its R/I-type fields; purely combinational.
module instr_field_split
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [IMM16_W-1:0]  imm16
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16  = instr[IMM16_MSB:IMM16_LSB];

endmodule

// File: rtl/if_id_queue.sv
// Elastic fetch-to-decode FIFO; the head entry is presented combinationally and
// pre-split into instruction fields, reading as a NOP whenever the queue is empty.
module if_id_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [DATA_W-1:0]          in_pc4,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [DATA_W-1:0]          out_pc4,
    output logic [OPCODE_W-1:0]        opcode,
    output logic [REG_W-1:0]           rs,
    output logic [REG_W-1:0]           rt,
    output logic [REG_W-1:0]           rd,
    output logic [SHAMT_W-1:0]         shamt,
    output logic [FUNCT_W-1:0]         funct,
    output logic [IMM16_W-1:0]         imm16,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] pc4_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic push;
    logic pop;

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // DEPTH is a power of two, so plain pointer increment wraps with no gap
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read once count covers it
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr_reg] <= in_instr;
            pc4_mem[wr_ptr_reg]   <= in_pc4;
        end
    end

    assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : DATA_W'(INSTR_NOP);
    assign out_pc4   = out_valid ? pc4_mem[rd_ptr_reg]   : '0;
    assign count     = count_reg;

    instr_field_split u_field_split (
        .instr  (out_instr),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm16  (imm16)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand sequences, and a randomized run
// checked against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr = '0;
    logic [DATA_W-1:0] in_pc4 = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc4;
    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [1:0]        count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .count     (count)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        fl;
        logic        ordy;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [1:0]  e_count;
        logic        e_in_ready;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares every output against the expected head/occupancy; fields are taken
    // from the architectural MIPS layout of the expected instruction.
    task automatic check_all(input string tag, input logic e_valid, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic [1:0] e_count, input logic e_rdy);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".out_instr"}, out_instr, e_instr);
        check({tag, ".out_pc4"},   out_pc4,   e_pc4);
        check({tag, ".count"},     32'(count), 32'(e_count));
        check({tag, ".in_ready"},  32'(in_ready), 32'(e_rdy));
        check({tag, ".fields"},
              {opcode, rs, rt, rd, shamt, funct},
              {e_instr[31:26], e_instr[25:21], e_instr[20:16], e_instr[15:11], e_instr[10:6], e_instr[5:0]});
        check({tag, ".imm16"}, 32'(imm16), 32'(e_instr[15:0]));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        in_pc4    = pc;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    vec_t   vecs [16];
    entry_t model_q [$];

    initial begin
        vecs[0]  = '{1, 32'h2008FFFC, 32'h4, 0, 0, 1, 32'h2008FFFC, 32'h4, 2'd1, 1};
        vecs[1]  = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 2'd0, 1};
        vecs[2]  = '{1, 32'h11111111, 32'h8, 0, 0, 1, 32'h11111111, 32'h8, 2'd1, 1};
        vecs[3]  = '{1, 32'h22222222, 32'hC, 0, 0, 1, 32'h11111111, 32'h8, 2'd2, 0};
        vecs[4]  = '{1, 32'h33333333, 32'h10, 0, 0, 1, 32'h11111111, 32'h8, 2'd2, 0};
        vecs[5]  = '{1, 32'h33333333, 32'h10, 0, 1, 1, 32'h22222222, 32'hC, 2'd1, 1};
        vecs[6]  = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 2'd0, 1};
        vecs[7]  = '{1, 32'hAAAA0001, 32'h14, 0, 0, 1, 32'hAAAA0001, 32'h14, 2'd1, 1};
        vecs[8]  = '{1, 32'hAAAA0002, 32'h18, 0, 0, 1, 32'hAAAA0001, 32'h14, 2'd2, 0};
        vecs[9]  = '{1, 32'hDEADBEEF, 32'h1C, 1, 1, 0, 32'h0, 32'h0, 2'd0, 1};
        vecs[10] = '{0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 2'd0, 1};
        vecs[11] = '{1, 32'h000000B1, 32'h20, 0, 0, 1, 32'h000000B1, 32'h20, 2'd1, 1};
        vecs[12] = '{1, 32'h000000B2, 32'h24, 0, 1, 1, 32'h000000B2, 32'h24, 2'd1, 1};
        vecs[13] = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 2'd0, 1};
        vecs[14] = '{1, 32'h012A4020, 32'h28, 0, 1, 1, 32'h012A4020, 32'h28, 2'd1, 1};
        vecs[15] = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 2'd0, 1};

        // Reset held from time zero
        #2;
        check_all("reset", 0, 32'h0, 32'h0, 2'd0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].instr, vecs[i].pc4, vecs[i].fl, vecs[i].ordy);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_pc4, vecs[i].e_count, vecs[i].e_in_ready);
            $display("vec %0d: valid=%0b instr=%h count=%0d in_ready=%0b",
                     i, out_valid, out_instr, count, in_ready);
        end

        // addi $t0,$zero,-4 decoded fields
        drive(1, 32'h2008FFFC, 32'h4, 0, 0);
        check("addi.opcode", 32'(opcode), 32'h08);
        check("addi.rs",     32'(rs),     32'h0);
        check("addi.rt",     32'(rt),     32'h8);
        check("addi.imm16",  32'(imm16),  32'hFFFC);
        drive(0, 0, 0, 0, 1);
        check_all("addi.drain", 0, 32'h0, 32'h0, 2'd0, 1);
        $display("addi fields: opcode=%h rs=%0d rt=%0d imm16=%h", opcode, rs, rt, imm16);

        // Streaming: one push and one pop per cycle across several pointer wraps
        drive(1, 32'd1, 32'd100, 0, 0);
        check_all("stream1", 1, 32'd1, 32'd100, 2'd1, 1);
        for (int v = 2; v <= 8; v++) begin
            drive(1, 32'(v), 32'(100 + v), 0, 1);
            check_all($sformatf("stream%0d", v), 1, 32'(v), 32'(100 + v), 2'd1, 1);
            $display("stream %0d: out_instr=%h count=%0d", v, out_instr, count);
        end
        drive(0, 0, 0, 0, 1);
        check_all("stream.end", 0, 32'h0, 32'h0, 2'd0, 1);

        // Asynchronous reset mid-operation, and flush while reset is held
        drive(1, 32'hCAFE0001, 32'h40, 0, 0);
        drive(1, 32'hCAFE0002, 32'h44, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 32'h0, 32'h0, 2'd0, 1);
        drive(1, 32'hCAFE0003, 32'h48, 1, 1);
        check_all("rst_hold", 0, 32'h0, 32'h0, 2'd0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset sequence: count=%0d out_valid=%0b", count, out_valid);

        // Randomized traffic against a FIFO model
        model_q.delete();
        for (int n = 0; n < 400; n++) begin
            logic        r_v, r_f, r_o, m_push, m_pop;
            logic [31:0] r_i, r_p;
            entry_t      e;
            r_v = ($urandom_range(0, 3) != 0);
            r_o = ($urandom_range(0, 2) != 0);
            r_f = ($urandom_range(0, 19) == 0);
            r_i = $urandom;
            r_p = $urandom;
            m_push = r_v && (model_q.size() < DEPTH);
            m_pop  = r_o && (model_q.size() != 0);
            if (r_f) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) begin
                    e.instr = r_i;
                    e.pc4   = r_p;
                    model_q.push_back(e);
                end
            end
            drive(r_v, r_i, r_p, r_f, r_o);
            if (model_q.size() != 0)
                check_all($sformatf("rnd%0d", n), 1, model_q[0].instr, model_q[0].pc4,
                          2'(model_q.size()), model_q.size() < DEPTH);
            else
                check_all($sformatf("rnd%0d", n), 0, 32'h0, 32'h0, 2'd0, 1);
            $display("rnd %0d: v=%0b f=%0b or=%0b -> valid=%0b instr=%h count=%0d",
                     n, r_v, r_f, r_o, out_valid, out_instr, count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Elastic fetch-to-decode buffer in the MIPS datapath.
- Holds fetched instructions with their PC+4 in a small FIFO and presents the head entry to decode, already split into fields.
- Its imm16 output feeds the 16-to-32 sign extender directly.
- Absorbs one-cycle decode stalls without back-pressuring fetch, and supports branch/jump flush.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, at least 2.
- DATA_W, 32, instruction and PC width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents in_instr/in_pc4.
- in_ready  out  1  queue can accept; high iff count < DEPTH.
- in_instr  in  DATA_W  fetched instruction word.
- in_pc4  in  DATA_W  PC+4 of that instruction.
- flush  in  1  discard all buffered entries (taken branch/jump).
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  decode consumes head this cycle.
- out_instr  out  DATA_W  head instruction; 32'h0 (NOP) when !out_valid.
- out_pc4  out  DATA_W  head PC+4; 0 when !out_valid.
- opcode  out  6  out_instr[31:26].
- rs  out  5  out_instr[25:21].
- rt  out  5  out_instr[20:16].
- rd  out  5  out_instr[15:11].
- shamt  out  5  out_instr[10:6].
- funct  out  6  out_instr[5:0].
- imm16  out  16  out_instr[15:0]; goes to the sign extender.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset: async assert on rst_n low. Clears wr_ptr, rd_ptr and count to 0. Storage contents are don't-care.
  - Resulting outputs: in_ready=1, out_valid=0, out_instr=0, out_pc4=0, all field outputs 0.
  - Reset deassertion is synchronised externally.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Clock edge, no flush:
  - push writes mem[wr_ptr]; wr_ptr increments mod DEPTH.
  - pop increments rd_ptr mod DEPTH.
  - count updates by +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1). There is no same-cycle bypass.
- Outputs are combinational from mem[rd_ptr] and count. All field outputs are slices of out_instr, so they read 0 (NOP, sll $0,$0,0) when empty.
- Full (count=DEPTH): in_ready=0, so any in_valid is ignored. Simultaneous pop frees one slot, but in_ready for that cycle is still 0 because it does not depend on out_ready.
- Empty (count=0): out_valid=0, and out_ready is ignored. A push in that cycle is not visible until the next cycle.
- Simultaneous push and pop at 0<count<DEPTH: both occur and count is unchanged.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- flush (synchronous, highest priority):
  - Next state is wr_ptr=rd_ptr=count=0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is irrelevant.
  - in_ready is not gated by flush.
- flush during reset has no effect. Reset mid-operation discards all entries immediately (async).
- Fetch must hold in_instr/in_pc4 stable while in_valid & !in_ready. The queue does not check this.

Decomposition:
- Shared package mips_pkg holds:
  - field bit positions and widths (OPCODE_MSB/LSB, RS, RT, RD, SHAMT, FUNCT, IMM16);
  - INSTR_NOP = 32'h0000_0000;
  - DATA_W default.
- One natural combinational sub-module, instr_field_split: takes out_instr and produces opcode/rs/rt/rd/shamt/funct/imm16. It is reused by later pipeline registers.
- The FIFO core stays inline.

Test Plan:
- Reset, then idle: rst_n=0 mid-cycle. Outputs clear immediately: out_valid=0, out_instr=0, in_ready=1, count=0.
- Single push, addi $t0,$zero,-4 (32'h2008FFFC) with pc4=32'h4, out_ready=0:
  - next cycle out_valid=1, opcode=6'h08, rs=0, rt=8, imm16=16'hFFFC, count=1;
  - then out_ready=1 gives out_valid=0 the cycle after.
- Fill to full: push 32'h11111111 then 32'h22222222 with out_ready=0.
  - count=2, in_ready=0;
  - a third push of 32'h33333333 is ignored;
  - draining yields 11111111 then 22222222, then empty.
- Streaming with wrap: push and pop every cycle for 8 cycles, values 1..8.
  - Each appears on out_instr exactly one cycle after its push.
  - count stays 1 and the pointers wrap at least 3 times.
- Flush with push: count=2, flush=1 and in_valid=1 (32'hDEADBEEF) in the same cycle.
  - Next cycle count=0, out_valid=0; DEADBEEF never appears.
- Push and pop at count=1: count stays 1 and the new entry becomes head the next cycle.
